// File: rtl/stopwatch_counter.sv
// Stopwatch counter: MM:SS BCD time base with run/pause/adjust control.
// unit_clock and blink_clock are slow, asynchronous tick sources; they are
// synchronized and edge-detected here. The edge detector is held off until
// its previous-value flop holds a real post-reset sample. A level that is
// already high when reset releases therefore does not count as a tick.
module stopwatch_counter (
    input  logic       internal_clk,
    input  logic       reset,
    input  logic       unit_clock,
    input  logic       blink_clock,
    input  logic       pause_btn,
    input  logic       clear,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] blank,
    output logic       running
);

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        ADJUST = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       resume_run;
    logic       resume_run_next;

    logic       unit_sync1, unit_sync2, unit_prev;
    logic       blink_sync1, blink_sync2, blink_prev;
    logic [2:0] fill;
    logic       unit_tick, blink_tick;

    logic [3:0] min_tens_next, min_ones_next, sec_tens_next, sec_ones_next;
    logic [3:0] blank_next;

    // Advance a two-digit BCD field by one, wrapping 59 -> 00.
    function automatic logic [7:0] inc59(input logic [3:0] tens, input logic [3:0] ones);
        if (ones == 4'd9)
            return (tens == 4'd5) ? 8'h00 : {tens + 4'd1, 4'd0};
        else
            return {tens, ones + 4'd1};
    endfunction

    // Synchronizers, previous-value flops, and post-reset fill tracker.
    always_ff @(posedge internal_clk or posedge reset) begin
        if (reset) begin
            unit_sync1  <= 1'b0;
            unit_sync2  <= 1'b0;
            unit_prev   <= 1'b0;
            blink_sync1 <= 1'b0;
            blink_sync2 <= 1'b0;
            blink_prev  <= 1'b0;
            fill        <= 3'b000;
        end else begin
            unit_sync1  <= unit_clock;
            unit_sync2  <= unit_sync1;
            unit_prev   <= unit_sync2;
            blink_sync1 <= blink_clock;
            blink_sync2 <= blink_sync1;
            blink_prev  <= blink_sync2;
            fill        <= {fill[1:0], 1'b1};
        end
    end

    // fill[2] marks the prev flops as holding genuine samples, not reset zeros.
    assign unit_tick  = unit_sync2 & ~unit_prev & fill[2];
    assign blink_tick = blink_sync2 & ~blink_prev & fill[2];

    // State and resume-flag register.
    always_ff @(posedge internal_clk or posedge reset) begin
        if (reset) begin
            state      <= PAUSED;
            resume_run <= 1'b0;
        end else begin
            state      <= state_next;
            resume_run <= resume_run_next;
        end
    end

    // Next-state logic; adj wins over pause_btn, pause_btn is ignored in ADJUST.
    always_comb begin
        state_next      = state;
        resume_run_next = resume_run;
        case (state)
            PAUSED: begin
                if (adj) begin
                    state_next      = ADJUST;
                    resume_run_next = 1'b0;
                end else if (pause_btn) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (adj) begin
                    state_next      = ADJUST;
                    resume_run_next = 1'b1;
                end else if (pause_btn) begin
                    state_next = PAUSED;
                end
            end
            ADJUST: begin
                if (!adj)
                    state_next = resume_run ? RUN : PAUSED;
            end
            default: state_next = PAUSED;
        endcase
    end

    // Next time value; tick effects use the current state, clear overrides all.
    always_comb begin
        min_tens_next = min_tens;
        min_ones_next = min_ones;
        sec_tens_next = sec_tens;
        sec_ones_next = sec_ones;
        if (clear) begin
            min_tens_next = 4'd0;
            min_ones_next = 4'd0;
            sec_tens_next = 4'd0;
            sec_ones_next = 4'd0;
        end else if (state == RUN && unit_tick) begin
            {sec_tens_next, sec_ones_next} = inc59(sec_tens, sec_ones);
            if (sec_tens == 4'd5 && sec_ones == 4'd9)
                {min_tens_next, min_ones_next} = inc59(min_tens, min_ones);
        end else if (state == ADJUST && blink_tick) begin
            if (sel)
                {min_tens_next, min_ones_next} = inc59(min_tens, min_ones);
            else
                {sec_tens_next, sec_ones_next} = inc59(sec_tens, sec_ones);
        end
    end

    // Blank pattern computed from next state; blink_sync1 is the upcoming sync2,
    // so the registered blank lines up with the registered state and sync2.
    always_comb begin
        blank_next = 4'b0000;
        if (state_next == ADJUST)
            blank_next = sel ? {blink_sync1, blink_sync1, 2'b00}
                             : {2'b00, blink_sync1, blink_sync1};
    end

    // Registered outputs.
    always_ff @(posedge internal_clk or posedge reset) begin
        if (reset) begin
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            blank    <= 4'b0000;
            running  <= 1'b0;
        end else begin
            min_tens <= min_tens_next;
            min_ones <= min_ones_next;
            sec_tens <= sec_tens_next;
            sec_ones <= sec_ones_next;
            blank    <= blank_next;
            running  <= (state_next == RUN);
        end
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: a seconds-based behavioural model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_stopwatch_counter;

    logic       internal_clk = 1'b0;
    logic       reset = 1'b1;
    logic       unit_clock = 1'b0;
    logic       blink_clock = 1'b0;
    logic       pause_btn = 1'b0;
    logic       clear = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones, blank;
    logic       running;

    int checks = 0;
    int failures = 0;
    int cyc_checks = 0;
    int cyc_failures = 0;

    stopwatch_counter dut (
        .internal_clk(internal_clk),
        .reset(reset),
        .unit_clock(unit_clock),
        .blink_clock(blink_clock),
        .pause_btn(pause_btn),
        .clear(clear),
        .adj(adj),
        .sel(sel),
        .min_tens(min_tens),
        .min_ones(min_ones),
        .sec_tens(sec_tens),
        .sec_ones(sec_ones),
        .blank(blank),
        .running(running)
    );

    always #5 internal_clk = ~internal_clk;

    // Behavioural model: time kept as total seconds 0..3599.
    localparam int S_P = 0, S_R = 1, S_A = 2;
    int         m_state = S_P;
    int         m_resume = S_P;
    int         m_nstate;
    int         m_total = 0;
    int         m_cnt = 0;
    logic [2:0] m_uh = 3'b000;
    logic [2:0] m_bh = 3'b000;
    logic [3:0] m_blank = 4'b0000;
    logic       m_running = 1'b0;
    logic       m_ut, m_bt;

    // A tick is a low-to-high step between two real samples taken since reset,
    // acted on two edges after the high sample.
    assign m_ut = (m_cnt >= 3) && m_uh[1] && !m_uh[2];
    assign m_bt = (m_cnt >= 3) && m_bh[1] && !m_bh[2];

    always_comb begin
        m_nstate = m_state;
        if (m_state == S_A) begin
            if (!adj) m_nstate = m_resume;
        end else if (adj) begin
            m_nstate = S_A;
        end else if (pause_btn) begin
            m_nstate = (m_state == S_R) ? S_P : S_R;
        end
    end

    always @(posedge internal_clk or posedge reset) begin
        if (reset) begin
            m_state   <= S_P;
            m_resume  <= S_P;
            m_total   <= 0;
            m_cnt     <= 0;
            m_uh      <= 3'b000;
            m_bh      <= 3'b000;
            m_blank   <= 4'b0000;
            m_running <= 1'b0;
        end else begin
            if (clear)
                m_total <= 0;
            else if (m_state == S_R && m_ut)
                m_total <= (m_total + 1) % 3600;
            else if (m_state == S_A && m_bt)
                m_total <= sel ? ((m_total / 60 + 1) % 60) * 60 + m_total % 60
                               : (m_total / 60) * 60 + (m_total % 60 + 1) % 60;
            if (m_state != S_A && adj) m_resume <= m_state;
            m_state   <= m_nstate;
            m_blank   <= (m_nstate != S_A) ? 4'b0000 :
                         sel ? {m_bh[0], m_bh[0], 2'b00} : {2'b00, m_bh[0], m_bh[0]};
            m_running <= (m_nstate == S_R);
            m_uh      <= {m_uh[1:0], unit_clock};
            m_bh      <= {m_bh[1:0], blink_clock};
            if (m_cnt < 3) m_cnt <= m_cnt + 1;
        end
    end

    logic [21:0] exp_v, dut_v;
    always_comb begin
        exp_v = {4'(m_total / 600), 4'((m_total / 60) % 10), 4'((m_total % 60) / 10),
                 4'(m_total % 10), m_blank, m_running};
        dut_v = {min_tens, min_ones, sec_tens, sec_ones, blank, running};
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge internal_clk) begin
        if (!reset) begin
            cyc_checks <= cyc_checks + 1;
            if (dut_v !== exp_v) begin
                cyc_failures <= cyc_failures + 1;
                $display("FAIL cycle t=%0t dut=%h model=%h", $time, dut_v, exp_v);
            end
        end
    end

    function automatic logic [15:0] dut_time();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge internal_clk);
        #2;
    endtask

    task automatic unit_pulse();
        unit_clock = 1'b1; cyc(3);
        unit_clock = 1'b0; cyc(3);
    endtask

    task automatic blink_pulse(input int n);
        repeat (n) begin
            blink_clock = 1'b1; cyc(3);
            blink_clock = 1'b0; cyc(3);
        end
    endtask

    task automatic pause_pulse();
        pause_btn = 1'b1; cyc();
        pause_btn = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc(3);
        chk("reset_time", dut_time(), 16'h0000);
        chk("reset_blank", blank, 4'b0000);
        chk("reset_running", running, 1'b0);
        reset = 1'b0;
        cyc(5);

        // Start, first-step latency, then three seconds
        pause_pulse();
        unit_clock = 1'b1;
        cyc(2);
        chk("latency_2edges", dut_time(), 16'h0000);
        cyc();
        chk("latency_3edges", dut_time(), 16'h0001);
        unit_clock = 1'b0; cyc(3);
        unit_pulse(); unit_pulse();
        chk("run_3s", dut_time(), 16'h0003);
        chk("run_running", running, 1'b1);

        // Preload 59:58 through ADJUST, resume RUN, full-scale wrap
        adj = 1'b1; sel = 1'b1; cyc(2);
        blink_pulse(59);
        sel = 1'b0;
        blink_pulse(55);
        chk("preload", dut_time(), 16'h5958);
        adj = 1'b0; cyc(2);
        chk("resume_run", running, 1'b1);
        unit_pulse();
        chk("to_5959", dut_time(), 16'h5959);
        unit_pulse();
        chk("wrap_0000", dut_time(), 16'h0000);

        // Seconds adjust from 00:09 in PAUSED
        repeat (9) unit_pulse();
        chk("at_0009", dut_time(), 16'h0009);
        pause_pulse(); cyc();
        chk("paused", running, 1'b0);
        adj = 1'b1; sel = 1'b0; blink_clock = 1'b1;
        cyc(4);
        chk("adj_blank_sec", blank, 4'b0011);
        blink_clock = 1'b0; cyc(3);
        blink_pulse(50);
        chk("adj_sec_wrap", dut_time(), 16'h0000);
        adj = 1'b0; cyc(3);
        chk("adj_exit_blank", blank, 4'b0000);
        chk("adj_exit_paused", running, 1'b0);

        // Clear coincident with a unit tick at 00:59 in RUN
        adj = 1'b1; cyc(2);
        blink_pulse(59);
        adj = 1'b0; cyc(2);
        chk("at_0059", dut_time(), 16'h0059);
        pause_pulse();
        unit_clock = 1'b1; cyc(2);
        clear = 1'b1; cyc();
        clear = 1'b0;
        chk("clear_tick", dut_time(), 16'h0000);
        chk("clear_running", running, 1'b1);
        unit_clock = 1'b0; cyc(3);

        // pause_btn coincident with a unit tick
        unit_clock = 1'b1; cyc(2);
        pause_btn = 1'b1; cyc();
        pause_btn = 1'b0;
        chk("pause_tick", dut_time(), 16'h0001);
        chk("pause_tick_run", running, 1'b0);
        unit_clock = 1'b0; cyc(3);
        unit_pulse();
        chk("paused_hold", dut_time(), 16'h0001);

        // Asynchronous reset in ADJUST at 12:34
        adj = 1'b1; sel = 1'b1; cyc(2);
        blink_pulse(12);
        sel = 1'b0;
        blink_pulse(33);
        chk("at_1234", dut_time(), 16'h1234);
        blink_clock = 1'b1; cyc(2);
        chk("blank_pre_reset", blank, 4'b0011);
        #1 reset = 1'b1;
        #1;
        chk("async_time", dut_time(), 16'h0000);
        chk("async_blank", blank, 4'b0000);
        chk("async_running", running, 1'b0);
        blink_clock = 1'b0; adj = 1'b0; unit_clock = 1'b1;
        cyc();
        reset = 1'b0;
        cyc(2);
        pause_pulse();
        cyc(5);
        chk("held_high_no_tick", dut_time(), 16'h0000);
        chk("post_reset_run", running, 1'b1);
        unit_clock = 1'b0; cyc(3);
        unit_clock = 1'b1; cyc(3);
        chk("fresh_edge_tick", dut_time(), 16'h0001);

        // Randomized traffic, checked by the per-cycle compare
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) unit_clock = ~unit_clock;
            if ($urandom_range(0, 3) == 0) blink_clock = ~blink_clock;
            pause_btn = ($urandom_range(0, 15) == 0);
            clear     = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 40) == 0) adj = ~adj;
            if ($urandom_range(0, 20) == 0) sel = ~sel;
            cyc();
        end
        pause_btn = 1'b0; clear = 1'b0; adj = 1'b0;
        cyc(4);

        checks   += cyc_checks;
        failures += cyc_failures;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
- internal_clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; returns all state to reset values.
- unit_clock  in  1  count tick source; one count per rising edge.
- blink_clock  in  1  adjust tick source and blink phase.
- pause_btn  in  1  one-cycle pulse, synchronous to internal_clk; toggles run/pause.
- clear  in  1  synchronous level; time forced to 00:00 while high.
- adj  in  1  level; 1 = adjust mode.
- sel  in  1  adjust field select; 0 = seconds, 1 = minutes.
- min_tens  out  4  BCD minutes tens, 0-5.
- min_ones  out  4  BCD minutes ones, 0-9.
- sec_tens  out  4  BCD seconds tens, 0-5.
- sec_ones  out  4  BCD seconds ones, 0-9.
- blank  out  4  per-digit blank: [3] min_tens, [2] min_ones, [1] sec_tens, [0] sec_ones.
- running  out  1  1 when in RUN state.

Function
REQ-003 unit_clock and blink_clock SHALL each pass through a 2-flop synchronizer and a previous-value register; tick = sync2 & ~prev.
REQ-004 The state machine SHALL have three states: PAUSED, RUN and ADJUST, plus a resume flag recording RUN or PAUSED.
REQ-005 PAUSED -> RUN on pause_btn; RUN -> PAUSED on pause_btn; PAUSED or RUN -> ADJUST when adj=1, saving the origin in the resume flag.
REQ-006 ADJUST -> the saved state when adj=0; pause_btn SHALL be ignored in ADJUST.
REQ-007 In RUN, each unit tick SHALL increment the time by one second: sec_ones 9 -> 0 carries into sec_tens; sec_tens 5 -> 0 carries into min_ones; min_ones 9 -> 0 carries into min_tens.
REQ-008 Full-scale wrap: 59:59 + 1 SHALL give 00:00.
REQ-009 In ADJUST, unit ticks SHALL be ignored; each blink tick SHALL increment only the field selected by sel, by 1, 59 -> 00, with no carry into the other field.
REQ-010 In PAUSED, time SHALL hold.
REQ-011 clear=1 SHALL load 00:00 on that edge in any state, taking priority over any same-cycle tick or adjust increment; the state is unchanged.
REQ-012 pause_btn coincident with a unit tick: the tick SHALL be applied according to the state before the toggle.
REQ-013 Latency: a time update SHALL be visible after the 3rd internal_clk rising edge, counting the first edge that samples unit_clock (or blink_clock) high.
REQ-014 blank SHALL be 0000 outside ADJUST.
REQ-015 In ADJUST, blank SHALL be the synchronized blink_clock level (sync2) replicated on the selected pair: sel=0 -> [1:0]; sel=1 -> [3:2]. The other bits SHALL be 0.
REQ-016 running SHALL be 1 only in RUN.
REQ-017 All outputs SHALL be registered.

Reset
REQ-018 Reset SHALL force the following values, independent of the clock: all BCD outputs 0, blank=0000, running=0, state PAUSED, resume flag PAUSED, synchronizer and previous-value flops 0.
REQ-019 Reset asserted mid-count or mid-adjust SHALL abort the operation with no partial update. After release, the first tick SHALL need a fresh rising edge on the synchronized input.

Verification
REQ-020 Reset, pulse pause_btn, apply 3 unit_clock rising edges -> running=1, time 00:03, each step appearing 3 edges after its input edge.
REQ-021 Preload via ADJUST to 59:58, return to RUN, apply 2 unit ticks -> 59:59, then 00:00.
REQ-022 PAUSED at 00:09, adj=1, sel=0, blink_clock high -> blank=0011; 51 blink ticks -> 00:00 with minutes unchanged; adj=0 -> PAUSED, blank=0000.
REQ-023 RUN at 00:59, clear asserted in the same cycle as a unit tick -> 00:00, running stays 1.
REQ-024 RUN, pause_btn in the same cycle as a unit tick -> count increments once, then running=0 and further ticks are ignored.
REQ-025 Assert reset asynchronously in ADJUST at 12:34 -> outputs 0 immediately; after release, a unit_clock held high produces no tick until it goes low then high again.
